// File: rtl/spi_load_sequencer.sv
// Boot loader for tt_um_tiny_processor: streams instruction and register images from a sync ROM
// over the processor's SPI MISO line, then hands MISO to the external device. Option: SPI_LOAD_MULTI_GROUP_EN.
module spi_load_sequencer #(
    parameter int DATA_W  = 8,
    parameter int N_INSTR = 16,
    parameter int N_REG   = 16,
    parameter int ADDR_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
`ifdef SPI_LOAD_MULTI_GROUP_EN
    input  logic [3:0]        n_groups,
`endif
    output logic [ADDR_W-1:0] img_addr,
    input  logic [DATA_W-1:0] img_data,
    input  logic              sclk,
    input  logic              cs,
    input  logic              done_in,
    output logic [1:0]        mode_out,
    output logic              mosi_out,
    output logic              sel_dev,
    output logic              busy,
    output logic              done_out
);

    localparam int BIT_W  = $clog2(DATA_W + 1);
    localparam int N_MAX  = (N_INSTR > N_REG) ? N_INSTR : N_REG;
    localparam int WCNT_W = $clog2(N_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_I    = 3'd1,
        ST_LOAD_R    = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_HANDOFF   = 3'd4,
        ST_GAP       = 3'd5
    } state_t;

    state_t              state_r, state_nx_s;
    logic [ADDR_W-1:0]   img_addr_r, img_addr_nx_s;
    logic [BIT_W-1:0]    bit_cnt_r, bit_cnt_nx_s;
    logic [WCNT_W-1:0]   word_cnt_r, word_cnt_nx_s;
    logic [1:0]          mode_r, mode_nx_s;
    logic                mosi_r, mosi_nx_s;
    logic                sel_dev_r, sel_dev_nx_s;
    logic                busy_r, busy_nx_s;
    logic                done_r, done_nx_s;
    logic                ld_req_r, ld_req_s;
    logic                ld_dly_r;
    logic [DATA_W-1:0]   word_r;
    logic [DATA_W-1:0]   word_sh_s;

    logic sclk_meta_r, sclk_sync_r, sclk_prev_r;
    logic cs_meta_r, cs_sync_r, cs_prev_r;
    logic done_meta_r, done_sync_r;
    logic sclk_rise_s, sclk_fall_s, cs_fall_s, cs_rise_s;
    logic start_acc_s;
    logic more_groups_s;

    // Two-flop synchronizers plus a history flop per SPI line for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_meta_r <= 1'b0;
            sclk_sync_r <= 1'b0;
            sclk_prev_r <= 1'b0;
            cs_meta_r   <= 1'b1;
            cs_sync_r   <= 1'b1;
            cs_prev_r   <= 1'b1;
            done_meta_r <= 1'b0;
            done_sync_r <= 1'b0;
        end else begin
            sclk_meta_r <= sclk;
            sclk_sync_r <= sclk_meta_r;
            sclk_prev_r <= sclk_sync_r;
            cs_meta_r   <= cs;
            cs_sync_r   <= cs_meta_r;
            cs_prev_r   <= cs_sync_r;
            done_meta_r <= done_in;
            done_sync_r <= done_meta_r;
        end
    end

    // Edge strobes and start qualification
    always_comb begin
        sclk_rise_s = sclk_sync_r & ~sclk_prev_r;
        sclk_fall_s = ~sclk_sync_r & sclk_prev_r;
        cs_fall_s   = ~cs_sync_r & cs_prev_r;
        cs_rise_s   = cs_sync_r & ~cs_prev_r;
        start_acc_s = start & ((state_r == ST_IDLE) | (state_r == ST_HANDOFF));
    end

`ifdef SPI_LOAD_MULTI_GROUP_EN
    logic [3:0] groups_r;
    logic [3:0] grp_cnt_r;

    // Group bookkeeping: count latched on start, index advanced per finished group
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            groups_r  <= 4'd1;
            grp_cnt_r <= 4'd0;
        end else if (start_acc_s) begin
            groups_r  <= (n_groups == 4'd0) ? 4'd1 : n_groups;
            grp_cnt_r <= 4'd0;
        end else if ((state_r == ST_WAIT_DONE) && done_sync_r && more_groups_s) begin
            grp_cnt_r <= grp_cnt_r + 4'd1;
        end else begin
            grp_cnt_r <= grp_cnt_r;
        end
    end

    // Another group follows when the current index is not the last one
    always_comb begin
        more_groups_s = ((grp_cnt_r + 4'd1) < groups_r);
    end
`else
    // Single-group build: every done_in ends the load
    always_comb begin
        more_groups_s = 1'b0;
    end
`endif

    // Next-state and next-output logic for the load sequencer
    always_comb begin
        state_nx_s    = state_r;
        img_addr_nx_s = img_addr_r;
        bit_cnt_nx_s  = bit_cnt_r;
        word_cnt_nx_s = word_cnt_r;
        mode_nx_s     = mode_r;
        mosi_nx_s     = mosi_r;
        sel_dev_nx_s  = sel_dev_r;
        busy_nx_s     = busy_r;
        done_nx_s     = 1'b0;
        ld_req_s      = 1'b0;
        word_sh_s     = word_r << bit_cnt_r;

        case (state_r)
            ST_IDLE, ST_HANDOFF: begin
                if (start_acc_s) begin
                    state_nx_s    = ST_LOAD_I;
                    img_addr_nx_s = ADDR_W'(0);
                    bit_cnt_nx_s  = BIT_W'(0);
                    word_cnt_nx_s = WCNT_W'(0);
                    mode_nx_s     = 2'b01;
                    mosi_nx_s     = 1'b0;
                    sel_dev_nx_s  = 1'b0;
                    busy_nx_s     = 1'b1;
                    ld_req_s      = 1'b1;
                end else begin
                    state_nx_s = state_r;
                end
            end

            ST_LOAD_I, ST_LOAD_R: begin
                // bit_cnt counts sampled rises, so it also indexes the next bit to present
                if (cs_fall_s) begin
                    mosi_nx_s = word_r[DATA_W-1];
                end else if (sclk_fall_s && (bit_cnt_r < BIT_W'(DATA_W))) begin
                    mosi_nx_s = word_sh_s[DATA_W-1];
                end else begin
                    mosi_nx_s = mosi_r;
                end

                if (sclk_rise_s) begin
                    if (bit_cnt_r == BIT_W'(DATA_W - 1)) begin
                        bit_cnt_nx_s  = BIT_W'(0);
                        img_addr_nx_s = img_addr_r + ADDR_W'(1);
                        ld_req_s      = 1'b1;
                        if ((state_r == ST_LOAD_I) && (word_cnt_r == WCNT_W'(N_INSTR - 1))) begin
                            state_nx_s    = ST_LOAD_R;
                            word_cnt_nx_s = WCNT_W'(0);
                            mode_nx_s     = 2'b10;
                        end else if ((state_r == ST_LOAD_R) && (word_cnt_r == WCNT_W'(N_REG - 1))) begin
                            state_nx_s    = ST_WAIT_DONE;
                            word_cnt_nx_s = WCNT_W'(0);
                            mode_nx_s     = 2'b00;
                            mosi_nx_s     = 1'b0;
                        end else begin
                            word_cnt_nx_s = word_cnt_r + WCNT_W'(1);
                        end
                    end else begin
                        bit_cnt_nx_s = bit_cnt_r + BIT_W'(1);
                    end
                end else if (cs_rise_s) begin
                    // Aborted word: rewind so the same word is resent on the next frame
                    bit_cnt_nx_s = BIT_W'(0);
                end else begin
                    bit_cnt_nx_s = bit_cnt_r;
                end
            end

            ST_WAIT_DONE: begin
                if (done_sync_r) begin
                    if (more_groups_s) begin
                        state_nx_s   = ST_GAP;
                        mode_nx_s    = 2'b00;
                        sel_dev_nx_s = 1'b0;
                    end else begin
                        state_nx_s   = ST_HANDOFF;
                        mode_nx_s    = 2'b11;
                        sel_dev_nx_s = 1'b1;
                        busy_nx_s    = 1'b0;
                        done_nx_s    = 1'b1;
                    end
                end else begin
                    state_nx_s = state_r;
                end
            end

            ST_GAP: begin
                // img_addr already sits at the next group's base
                state_nx_s    = ST_LOAD_I;
                bit_cnt_nx_s  = BIT_W'(0);
                word_cnt_nx_s = WCNT_W'(0);
                mode_nx_s     = 2'b01;
                sel_dev_nx_s  = 1'b0;
                ld_req_s      = 1'b1;
            end

            default: begin
                state_nx_s   = ST_IDLE;
                mode_nx_s    = 2'b00;
                mosi_nx_s    = 1'b0;
                sel_dev_nx_s = 1'b0;
                busy_nx_s    = 1'b0;
            end
        endcase
    end

    // State register and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            img_addr_r <= ADDR_W'(0);
            bit_cnt_r  <= BIT_W'(0);
            word_cnt_r <= WCNT_W'(0);
            mode_r     <= 2'b00;
            mosi_r     <= 1'b0;
            sel_dev_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            ld_req_r   <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            img_addr_r <= img_addr_nx_s;
            bit_cnt_r  <= bit_cnt_nx_s;
            word_cnt_r <= word_cnt_nx_s;
            mode_r     <= mode_nx_s;
            mosi_r     <= mosi_nx_s;
            sel_dev_r  <= sel_dev_nx_s;
            busy_r     <= busy_nx_s;
            done_r     <= done_nx_s;
            ld_req_r   <= ld_req_s;
        end
    end

    // ROM read pipeline: address registered, ROM registers it, then the word is captured
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_dly_r <= 1'b0;
            word_r   <= DATA_W'(0);
        end else begin
            ld_dly_r <= ld_req_r;
            if (ld_dly_r) begin
                word_r <= img_data;
            end else begin
                word_r <= word_r;
            end
        end
    end

    assign img_addr = img_addr_r;
    assign mode_out = mode_r;
    assign mosi_out = mosi_r;
    assign sel_dev  = sel_dev_r;
    assign busy     = busy_r;
    assign done_out = done_r;

endmodule

// File: tb/tb_spi_load_sequencer.sv
// Directed bench for spi_load_sequencer: SPI-master BFM, sync ROM model and an expected-word queue.
module tb_spi_load_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] img_addr;
    logic [7:0] img_data;
    logic       sclk;
    logic       cs;
    logic       done_in;
    logic [1:0] mode_out;
    logic       mosi_out;
    logic       sel_dev;
    logic       busy;
    logic       done_out;
`ifdef SPI_LOAD_MULTI_GROUP_EN
    logic [3:0] n_groups;
`endif

    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];

    spi_load_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
`ifdef SPI_LOAD_MULTI_GROUP_EN
        .n_groups (n_groups),
`endif
        .img_addr (img_addr),
        .img_data (img_data),
        .sclk     (sclk),
        .cs       (cs),
        .done_in  (done_in),
        .mode_out (mode_out),
        .mosi_out (mosi_out),
        .sel_dev  (sel_dev),
        .busy     (busy),
        .done_out (done_out)
    );

    always #5 clk = ~clk;

    // Sync ROM holding ROM[i] = i ^ 8'hA5
    always @(posedge clk) img_data <= img_addr ^ 8'hA5;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check(tag, {18'd0, mode_out, mosi_out, sel_dev, busy, done_out, img_addr}, 32'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic push_image(input int first, input int count);
        for (int i = first; i < first + count; i++) begin
            logic [7:0] a;
            a = i[7:0];
            exp_q.push_back(a ^ 8'hA5);
        end
    endtask

    task automatic partial_word(input int nbits);
        cs = 1'b0;
        tick(10);
        for (int b = 0; b < nbits; b++) begin
            sclk = 1'b1;
            tick(5);
            sclk = 1'b0;
            tick(5);
        end
        cs = 1'b1;
        tick(10);
    endtask

    // One full frame: mode/address checked at frame start, received byte against the queue head
    task automatic do_word(input int w, input logic [1:0] exp_mode);
        logic [7:0] rx;
        logic [7:0] e;
        rx = 8'd0;
        check($sformatf("mode_w%0d", w), {30'd0, mode_out}, {30'd0, exp_mode});
        check($sformatf("addr_w%0d", w), {24'd0, img_addr}, w);
        cs = 1'b0;
        tick(10);
        for (int b = 0; b < 8; b++) begin
            sclk = 1'b1;
            rx = {rx[6:0], mosi_out};
            tick(5);
            sclk = 1'b0;
            tick(5);
        end
        cs = 1'b1;
        tick(10);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        check($sformatf("data_w%0d", w), {24'd0, rx}, {24'd0, e});
    endtask

    // Raises done_in, optionally holding start over the synchronizer latency, and counts done_out pulses
    task automatic finish_load(input logic with_start, output int pulses);
        pulses = 0;
        done_in = 1'b1;
        start = with_start;
        for (int i = 0; i < 25; i++) begin
            if (i == 3) start = 1'b0;
            tick(1);
            if (done_out) pulses++;
        end
        start = 1'b0;
        done_in = 1'b0;
    endtask

    initial begin
        int pulses;
        rst_n = 1'b0;
        start = 1'b0;
        sclk = 1'b0;
        cs = 1'b1;
        done_in = 1'b0;
`ifdef SPI_LOAD_MULTI_GROUP_EN
        n_groups = 4'd0;
`endif
        tick(3);
        check_reset_vals("reset_vals");
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            check("idle", {27'd0, mode_out, sel_dev, busy, mosi_out, done_out}, 32'd0);
        end

        // Load 1: abort on word 3, spurious start during register word 7
        push_image(0, 32);
        pulse_start();
        check("start_mode", {30'd0, mode_out}, 32'd1);
        check("start_busy", {31'd0, busy}, 32'd1);
        check("start_sel", {31'd0, sel_dev}, 32'd0);
        tick(5);
        for (int w = 0; w < 32; w++) begin
            if (w == 3) partial_word(5);
            if (w == 23) begin
                pulse_start();
                check("busy_start_ignored", {31'd0, busy}, 32'd1);
            end
            do_word(w, (w < 16) ? 2'b01 : 2'b10);
        end
        tick(5);
        check("wait_mode", {30'd0, mode_out}, 32'd0);
        check("wait_busy", {31'd0, busy}, 32'd1);
        check("wait_mosi", {31'd0, mosi_out}, 32'd0);
        check("sb_drained1", exp_q.size(), 32'd0);

        // done_in with start held across it: done wins, start leaves no trace
        finish_load(1'b1, pulses);
        check("done_pulses1", pulses, 32'd1);
        check("ho_mode", {30'd0, mode_out}, 32'd3);
        check("ho_sel", {31'd0, sel_dev}, 32'd1);
        check("ho_busy", {31'd0, busy}, 32'd0);
        check("ho_addr_kept", {24'd0, img_addr}, 32'd32);
        tick(10);
        check("ho_hold", {28'd0, mode_out, sel_dev, busy}, 32'b1110);

        // Restart from HANDOFF, then reset during word 9
        pulse_start();
        check("restart_sel", {31'd0, sel_dev}, 32'd0);
        check("restart_addr", {24'd0, img_addr}, 32'd0);
        check("restart_mode", {30'd0, mode_out}, 32'd1);
        push_image(0, 9);
        tick(5);
        for (int w = 0; w < 9; w++) do_word(w, 2'b01);
        cs = 1'b0;
        tick(10);
        for (int b = 0; b < 3; b++) begin
            sclk = 1'b1;
            tick(5);
            sclk = 1'b0;
            tick(5);
        end
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async_reset");
        cs = 1'b1;
        sclk = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(3);
        check_reset_vals("post_reset_idle");

        // Reload after reset starts again at address 0
        pulse_start();
        check("reload_addr", {24'd0, img_addr}, 32'd0);
        check("reload_mode", {30'd0, mode_out}, 32'd1);
        push_image(0, 32);
        tick(5);
        for (int w = 0; w < 32; w++) do_word(w, (w < 16) ? 2'b01 : 2'b10);
        tick(5);
        check("wait_mode2", {30'd0, mode_out}, 32'd0);
        finish_load(1'b0, pulses);
        check("done_pulses2", pulses, 32'd1);
        check("ho2", {28'd0, mode_out, sel_dev, busy}, 32'b1110);
        check("sb_drained2", exp_q.size(), 32'd0);

`ifdef SPI_LOAD_MULTI_GROUP_EN
        // Two groups back to back, one done_out at the very end
        n_groups = 4'd2;
        pulse_start();
        push_image(0, 64);
        tick(5);
        for (int w = 0; w < 64; w++) begin
            if (w == 32) begin
                tick(5);
                check("mg_wait_mode", {30'd0, mode_out}, 32'd0);
                pulses = 0;
                done_in = 1'b1;
                for (int i = 0; i < 25; i++) begin
                    tick(1);
                    if (done_out) pulses++;
                    if (mode_out == 2'b01) break;
                end
                done_in = 1'b0;
                check("mg_no_mid_done", pulses, 32'd0);
                check("mg_gap_sel", {31'd0, sel_dev}, 32'd0);
                check("mg_busy", {31'd0, busy}, 32'd1);
                tick(5);
            end
            do_word(w, ((w % 32) < 16) ? 2'b01 : 2'b10);
        end
        tick(5);
        finish_load(1'b0, pulses);
        check("mg_done_pulses", pulses, 32'd1);
        check("mg_ho", {28'd0, mode_out, sel_dev, busy}, 32'b1110);
        check("mg_sb_drained", exp_q.size(), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
